// File: rtl/extra_args_div_pkg.sv
// Shared types and helpers for the ExtraArgs inverse divider.
// Holds the FSM state encoding, the default forward-path constants reduced
// to the default width, and the dividend reconstruction function.
package extra_args_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NBITS_DFLT  = 8;
  localparam int MYARG1_DFLT = 17;
  localparam int MYARG2_DFLT = 21;

  // Mask selecting the low nbits bits of a 32-bit word (nbits in 1..32).
  function automatic logic [31:0] width_mask(input int unsigned nbits);
    if (nbits >= 32) begin
      return '1;
    end
    return (32'd1 << nbits) - 32'd1;
  endfunction

  localparam logic [31:0] MYARG1_RED = 32'(MYARG1_DFLT) & width_mask(NBITS_DFLT);
  localparam logic [31:0] MYARG2_RED = 32'(MYARG2_DFLT) & width_mask(NBITS_DFLT);

  // Undo the forward path: D = (xout - arg1 + arg2) mod 2^nbits.
  // The constants are reduced to nbits first, so any integer value is legal.
  function automatic logic [31:0] adjust(input logic [31:0] xout,
                                         input int unsigned nbits,
                                         input int          arg1,
                                         input int          arg2);
    logic [31:0] mask;
    logic [31:0] a1;
    logic [31:0] a2;
    mask = width_mask(nbits);
    a1   = 32'(arg1) & mask;
    a2   = 32'(arg2) & mask;
    return (xout - a1 + a2) & mask;
  endfunction

endpackage

// File: rtl/extra_args_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module extra_args_div_step
  import extra_args_div_pkg::*;
#(
  parameter int NBITS = NBITS_DFLT
) (
  input  logic [NBITS-1:0] rem,
  input  logic             din,
  input  logic [NBITS-1:0] divisor,
  output logic [NBITS-1:0] rem_next,
  output logic             q_bit
);

  logic [NBITS:0] shifted;
  logic [NBITS:0] diff;

  // The incoming remainder is always below the divisor, so the shifted value
  // is below twice the divisor; the borrow out of the (NBITS+1)-bit subtract
  // therefore tells exactly whether the divisor fits.
  always_comb begin
    shifted  = {rem, din};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[NBITS];
    rem_next = q_bit ? diff[NBITS-1:0] : shifted[NBITS-1:0];
  end

endmodule

// File: rtl/extra_args_divider.sv
// Inverse of the ExtraArgs datapath. Given XOUT and B it rebuilds the
// wrapped dividend D = (XOUT - MYARG1 + MYARG2) mod 2^NBITS and divides it
// by B with a restoring divider producing one quotient bit per clock.
// Valid/ready on both sides, no overlap between operations. NBITS is 1..32.
module extra_args_divider
  import extra_args_div_pkg::*;
#(
  parameter int NBITS  = NBITS_DFLT,
  parameter int MYARG1 = MYARG1_DFLT,
  parameter int MYARG2 = MYARG2_DFLT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NBITS-1:0] XOUT,
  input  logic [NBITS-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NBITS-1:0] Q,
  output logic [NBITS-1:0] R,
  output logic             DIVZ
);

  localparam int            CW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  state_t           state;
  state_t           state_next;

  // dq starts as the dividend; each step shifts its MSB out into the
  // remainder and shifts the new quotient bit in at the LSB, so after NBITS
  // steps it holds the quotient.
  logic [NBITS-1:0] dq;
  logic [NBITS-1:0] rem;
  logic [NBITS-1:0] divisor;
  logic [CW-1:0]    cnt;

  logic [NBITS-1:0] d_in;
  logic [NBITS-1:0] step_rem;
  logic             step_q;
  logic [NBITS-1:0] dq_shifted;

  logic             accept;
  logic             deliver;
  logic             calc_last;

  assign d_in       = NBITS'(adjust(32'(XOUT), NBITS, MYARG1, MYARG2));
  assign accept     = IN_VALID & IN_READY;
  assign deliver    = OUT_VALID & OUT_READY;
  assign calc_last  = (state == CALC) && (cnt == '0);
  assign dq_shifted = (dq << 1) | NBITS'(step_q);

  extra_args_div_step #(
    .NBITS(NBITS)
  ) u_step (
    .rem     (rem),
    .din     (dq[NBITS-1]),
    .divisor (divisor),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  // State register; reset drops any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection: zero divisor skips straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (calc_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (deliver) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE:    IN_READY  = 1'b1;
      DONE:    OUT_VALID = 1'b1;
      default: begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, and load the
  // result registers once. Results persist after delivery.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dq      <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      Q       <= '0;
      R       <= '0;
      DIVZ    <= 1'b0;
    end else begin
      if (accept) begin
        dq      <= d_in;
        divisor <= B;
        rem     <= '0;
        cnt     <= CNT_LAST;
        if (B == '0) begin
          Q    <= '1;
          R    <= d_in;
          DIVZ <= 1'b1;
        end
      end else if (state == CALC) begin
        dq  <= dq_shifted;
        rem <= step_rem;
        if (calc_last) begin
          Q    <= dq_shifted;
          R    <= step_rem;
          DIVZ <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
